// File: rtl/rx_frame_fifo_if.sv
// AXI-Stream style beat bundle used on both sides of rx_frame_fifo.
// master drives the beat, slave returns tready.
interface rx_frame_fifo_if #(
    parameter int DATA_WIDTH = 64
);
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tkeep;
    logic                    tvalid;
    logic                    tlast;
    logic                    tuser;
    logic                    tready;

    modport master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
    modport slave  (input tdata, tkeep, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/rx_frame_fifo.sv
// Store-and-forward receive frame FIFO: frames become readable only once committed
// by their tlast beat; errored or overflowing frames are rewound and counted.
//
// state     | meaning
// ST_ACCEPT | storing beats of the current frame (reset state)
// ST_DROP   | discarding the rest of a frame that hit a full FIFO
module rx_frame_fifo #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 512,
    parameter int DROP_BAD   = 1
) (
    input  logic                 i_rxc,
    input  logic                 i_reset_n,
    rx_frame_fifo_if.slave       s00_axis,
    rx_frame_fifo_if.master      m00_axis,
    output logic [31:0]          o_drop_count,
    output logic [31:0]          o_overflow_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int KW = DATA_WIDTH / 8;
    localparam int EW = DATA_WIDTH + KW + 2;
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

    typedef enum logic {ST_ACCEPT, ST_DROP} state_t;

    logic [EW-1:0]         mem [DEPTH];
    logic [PW-1:0]         wr_ptr, commit_ptr, rd_ptr, wr_next;
    state_t                state;
    logic                  rdy_q;
    logic                  beat, full, wr_en;
    logic                  s1_vld, s1_adv, rd_en, out_ld;
    logic [EW-1:0]         s1_data;
    logic [DATA_WIDTH-1:0] m_data;
    logic [KW-1:0]         m_keep;
    logic                  m_vld, m_last, m_user;

    always_comb begin
        beat    = s00_axis.tvalid && rdy_q;
        // fullness is judged against rd_ptr before this edge's read
        full    = (wr_ptr - rd_ptr) == DEPTH_P;
        wr_en   = beat && (state == ST_ACCEPT) && !full;
        wr_next = wr_ptr + 1'b1;
        out_ld  = s1_vld && (!m_vld || m00_axis.tready);
        s1_adv  = !s1_vld || out_ld;
        rd_en   = s1_adv && (rd_ptr != commit_ptr);
    end

    // storage and the registered memory read carry no reset
    always_ff @(posedge i_rxc) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= {s00_axis.tuser & s00_axis.tlast, s00_axis.tlast,
                                    s00_axis.tkeep, s00_axis.tdata};
        end
        if (rd_en) begin
            s1_data <= mem[rd_ptr[AW-1:0]];
        end
    end

    always_ff @(posedge i_rxc or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state            <= ST_ACCEPT;
            rdy_q            <= 1'b0;
            wr_ptr           <= '0;
            commit_ptr       <= '0;
            rd_ptr           <= '0;
            o_drop_count     <= '0;
            o_overflow_count <= '0;
            s1_vld           <= 1'b0;
            m_vld            <= 1'b0;
            m_last           <= 1'b0;
            m_user           <= 1'b0;
            m_keep           <= '0;
            m_data           <= '0;
        end else begin
            rdy_q <= 1'b1;
            case (state)
                ST_ACCEPT: begin
                    if (beat) begin
                        if (full) begin
                            wr_ptr <= commit_ptr;
                            if (o_overflow_count != '1) o_overflow_count <= o_overflow_count + 1'b1;
                            if (!s00_axis.tlast) state <= ST_DROP;
                        end else if (s00_axis.tlast) begin
                            if (s00_axis.tuser && DROP_BAD != 0) begin
                                wr_ptr <= commit_ptr;
                                if (o_drop_count != '1) o_drop_count <= o_drop_count + 1'b1;
                            end else begin
                                wr_ptr     <= wr_next;
                                commit_ptr <= wr_next;
                            end
                        end else begin
                            wr_ptr <= wr_next;
                        end
                    end
                end
                ST_DROP: begin
                    if (beat && s00_axis.tlast) state <= ST_ACCEPT;
                end
                default: state <= ST_ACCEPT;
            endcase

            if (s1_adv) s1_vld <= rd_en;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;

            if (out_ld) begin
                {m_user, m_last, m_keep, m_data} <= s1_data;
                m_vld <= 1'b1;
            end else if (m00_axis.tready) begin
                m_vld <= 1'b0;
            end
        end
    end

    assign s00_axis.tready = rdy_q;
    assign m00_axis.tvalid = m_vld;
    assign m00_axis.tdata  = m_data;
    assign m00_axis.tkeep  = m_keep;
    assign m00_axis.tlast  = m_last;
    assign m00_axis.tuser  = m_user;
endmodule

// File: doc/rx_frame_fifo.md
RX_FRAME_FIFO -- requirements
Module: rx_frame_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, AXIS data width; legal values 32 and 64.
REQ-002 SHALL have parameter DEPTH, default 512, storage depth in beats; power of 2, at least 16.
REQ-003 SHALL have parameter DROP_BAD, default 1; 1 discards errored frames, 0 forwards them flagged.
REQ-004 SHALL have one clock and an asynchronous, active-low reset.
REQ-005 i_rxc  input  1  sole clock, rising edge.
REQ-006 i_reset_n  input  1  asynchronous active-low reset.
REQ-007 s00_axis_tdata  input  DATA_WIDTH  ingress beat data.
REQ-008 s00_axis_tkeep  input  DATA_WIDTH/8  ingress byte enables.
REQ-009 s00_axis_tvalid / s00_axis_tlast / s00_axis_tuser  input  1 each  ingress valid, end of frame, frame error (sampled with tlast).
REQ-010 s00_axis_tready  output  1  constant 1 out of reset; the source cannot be stalled.
REQ-011 m00_axis_tdata / m00_axis_tkeep  output  DATA_WIDTH / DATA_WIDTH/8  egress beat.
REQ-012 m00_axis_tvalid / m00_axis_tlast / m00_axis_tuser  output  1 each  egress valid, end of frame, error flag.
REQ-013 m00_axis_tready  input  1  egress backpressure.
REQ-014 o_drop_count  output  32  count of errored frames discarded.
REQ-015 o_overflow_count  output  32  count of frames truncated by full FIFO and discarded.

Function
REQ-016 SHALL operate as store-and-forward: no beat of a frame SHALL appear on m00 before that frame's tlast is accepted and committed.
REQ-017 SHALL keep wr_ptr, commit_ptr and rd_ptr, each log2(DEPTH)+1 bits wide, wrapping modulo 2*DEPTH.
REQ-018 SHALL treat the FIFO as full when wr_ptr - rd_ptr == DEPTH; capacity SHALL be exactly DEPTH beats.
REQ-019 SHALL treat the FIFO as empty for reading when rd_ptr == commit_ptr.
REQ-020 The ingress FSM SHALL have two states: ACCEPT (reset state) and DROP.
REQ-021 In ACCEPT, when a valid beat arrives and the FIFO is not full, the block SHALL store tdata, tkeep, tlast and tuser and increment wr_ptr.
REQ-022 In ACCEPT, a stored tlast beat with tuser=0 SHALL set commit_ptr to the new wr_ptr on the same edge.
REQ-023 In ACCEPT, a stored tlast beat with tuser=1 and DROP_BAD=1 SHALL rewind wr_ptr to commit_ptr and increment o_drop_count.
REQ-024 With DROP_BAD=0, a tlast beat with tuser=1 SHALL be committed per REQ-022, and m00_axis_tuser SHALL be 1 on that frame's last beat.
REQ-025 In ACCEPT, a valid beat arriving while the FIFO is full SHALL rewind wr_ptr to commit_ptr and increment o_overflow_count.
REQ-026 On that full beat, the FSM SHALL go to DROP if the beat has tlast=0, and stay in ACCEPT if tlast=1.
REQ-027 In DROP, the block SHALL discard all beats and SHALL return to ACCEPT on the edge accepting a tlast beat; the next beat SHALL begin a new frame.
REQ-028 A single-beat frame (tvalid and tlast on the first beat) SHALL be legal.
REQ-029 Egress read latency SHALL be 1 cycle from memory, using an output register that is refilled when empty or when tvalid and tready are both high.
REQ-030 After a commit edge with the FIFO previously empty, m00_axis_tvalid SHALL rise at the second following rising edge.
REQ-031 m00 outputs SHALL be held stable while tvalid=1 and tready=0.
REQ-032 With no stall, egress SHALL sustain 1 beat per cycle.
REQ-033 Simultaneous write, commit, rewind and read in one cycle SHALL all take effect with no lost beat; fullness SHALL use rd_ptr before that edge's read.
REQ-034 Both counters SHALL saturate at 0xFFFFFFFF.
REQ-035 m00_axis_tkeep SHALL always equal the stored ingress tkeep; on non-last beats it SHALL be all ones.

Reset
REQ-036 Asserting i_reset_n low at any time SHALL immediately force all pointers to 0, the FSM to ACCEPT, and both counters to 0.
REQ-037 During reset, m00_axis_tvalid, m00_axis_tlast, m00_axis_tuser, m00_axis_tdata and m00_axis_tkeep SHALL all be 0.
REQ-038 Any partial or committed frame held when reset asserts SHALL be discarded.
REQ-039 s00_axis_tready SHALL be 0 during reset and 1 from the first edge after release.

Verification
REQ-040 Scenario: 3-beat good frame, tready=1 -> identical 3 beats out; tvalid rises 2 edges after the tlast edge; last tkeep=0x0F passes through.
REQ-041 Scenario: DROP_BAD=1, 4-beat frame with tuser=1, then 2-beat good frame -> only the 2-beat frame appears; o_drop_count=1.
REQ-042 Scenario: DROP_BAD=0, same stimulus as REQ-041 -> both frames appear; tuser=1 on the first frame's last beat; o_drop_count=0.
REQ-043 Scenario: DEPTH=16, tready=0, 10-beat frame then 10-beat frame, then tready=1 -> only the first frame emerges; o_overflow_count=1; a following 3-beat frame emerges intact.
REQ-044 Scenario: random tready at 50%, 200 random frames of 1-40 beats with 10% errored -> the output matches a reference model of good frames; drop count matches.
REQ-045 Scenario: reset asserted mid-frame and mid-egress -> outputs are 0 at once; after release, a new frame passes correctly and counters restart from 0.
